riscv_multicycle_core: RTL

//  Multi-cycle RV32I-subset core: datapath, register file and control FSM in one block.

---
 rtl/riscv_multicycle_core.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32I-subset core (lw/sw, R/I ALU ops, beq, jal) with one shared
// instruction/data memory port using a registered req / ready handshake.
module riscv_multicycle_core #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          REG_COUNT = 32,
  parameter int          ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc_out,
  output logic              trap,
  input  logic [4:0]        dbg_raddr,
  output logic [31:0]       dbg_rdata
);
  localparam int          RIDX_W    = $clog2(REG_COUNT);
  localparam logic [31:0] REG_LIMIT = REG_COUNT;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next, oldpc_reg, oldpc_next, ir_reg, ir_next;
  logic [31:0] a_reg, a_next, b_reg, b_next, aluout_reg, aluout_next;
  logic [31:0] data_reg, data_next;
  logic        req_reg, req_next, we_reg, we_next;
  logic [31:0] regs [REG_COUNT];

  logic        rf_we;
  logic [31:0] rf_wdata;

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;
  logic [31:0] alu_b, alu_y, addr_calc, br_target, jal_target;
  logic        complete, legal;
  state_t      dec_state;

  function automatic logic reg_ok(input logic [4:0] r);
    return {27'd0, r} < REG_LIMIT;
  endfunction

  assign opcode = ir_reg[6:0];
  assign rd     = ir_reg[11:7];
  assign funct3 = ir_reg[14:12];
  assign rs1    = ir_reg[19:15];
  assign rs2    = ir_reg[24:20];
  assign funct7 = ir_reg[31:25];

  assign imm_i = {{20{ir_reg[31]}}, ir_reg[31:20]};
  assign imm_s = {{20{ir_reg[31]}}, ir_reg[31:25], ir_reg[11:7]};
  assign imm_b = {{19{ir_reg[31]}}, ir_reg[31], ir_reg[7], ir_reg[30:25], ir_reg[11:8], 1'b0};
  assign imm_j = {{11{ir_reg[31]}}, ir_reg[31], ir_reg[19:12], ir_reg[20], ir_reg[30:21], 1'b0};

  assign addr_calc  = a_reg + ((opcode == OP_SW) ? imm_s : imm_i);
  assign br_target  = oldpc_reg + imm_b;
  assign jal_target = oldpc_reg + imm_j;
  assign complete   = req_reg & mem_ready;

  // Legality covers opcode, funct fields and every register index the op uses.
  always_comb begin
    legal     = 1'b0;
    dec_state = S_TRAP;
    case (opcode)
      OP_LW:  begin legal = (funct3 == 3'b010) && reg_ok(rs1) && reg_ok(rd);  dec_state = S_MEMADR; end
      OP_SW:  begin legal = (funct3 == 3'b010) && reg_ok(rs1) && reg_ok(rs2); dec_state = S_MEMADR; end
      OP_R: begin
        legal = (((funct7 == 7'h00) && (funct3 inside {3'b000, 3'b111, 3'b110, 3'b010})) ||
                 ((funct7 == 7'h20) && (funct3 == 3'b000))) &&
                reg_ok(rs1) && reg_ok(rs2) && reg_ok(rd);
        dec_state = S_EXEC_R;
      end
      OP_I: begin
        legal = (funct3 inside {3'b000, 3'b111, 3'b110, 3'b010}) && reg_ok(rs1) && reg_ok(rd);
        dec_state = S_EXEC_I;
      end
      OP_BEQ: begin legal = (funct3 == 3'b000) && reg_ok(rs1) && reg_ok(rs2); dec_state = S_BEQ; end
      OP_JAL: begin legal = reg_ok(rd); dec_state = S_JAL; end
      default: begin legal = 1'b0; dec_state = S_TRAP; end
    endcase
  end

  always_comb begin
    alu_b = (state_reg == S_EXEC_R) ? b_reg : imm_i;
    case (funct3)
      3'b000:  alu_y = (state_reg == S_EXEC_R && funct7[5]) ? a_reg - alu_b : a_reg + alu_b;
      3'b111:  alu_y = a_reg & alu_b;
      3'b110:  alu_y = a_reg | alu_b;
      3'b010:  alu_y = {31'd0, $signed(a_reg) < $signed(alu_b)};
      default: alu_y = 32'd0;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    oldpc_next  = oldpc_reg;
    ir_next     = ir_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    aluout_next = aluout_reg;
    data_next   = data_reg;
    rf_we       = 1'b0;
    rf_wdata    = aluout_reg;
    case (state_reg)
      S_FETCH: if (complete) begin
        ir_next    = mem_rdata;
        oldpc_next = pc_reg;
        pc_next    = pc_reg + 32'd4;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        a_next     = regs[rs1[RIDX_W-1:0]];
        b_next     = regs[rs2[RIDX_W-1:0]];
        state_next = legal ? dec_state : S_TRAP;
      end
      S_MEMADR: begin
        aluout_next = addr_calc;
        if (addr_calc[1:0] != 2'b00) state_next = S_TRAP;
        else                         state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: if (complete) begin
        data_next  = mem_rdata;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        rf_we      = 1'b1;
        rf_wdata   = data_reg;
        state_next = S_FETCH;
      end
      S_MEMWR: if (complete) state_next = S_FETCH;
      S_EXEC_R, S_EXEC_I: begin
        aluout_next = alu_y;
        state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we      = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        state_next = S_FETCH;
        if (a_reg == b_reg) begin
          if (br_target[1]) state_next = S_TRAP;
          else              pc_next    = br_target;
        end
      end
      S_JAL: begin
        if (jal_target[1]) begin
          state_next = S_TRAP;
        end else begin
          rf_we      = 1'b1;
          rf_wdata   = oldpc_reg + 32'd4;
          pc_next    = jal_target;
          state_next = S_FETCH;
        end
      end
      default: state_next = S_TRAP;
    endcase
    // Request rises one cycle after entering a memory state and drops after completion.
    req_next = (state_reg inside {S_FETCH, S_MEMRD, S_MEMWR}) && !complete;
    we_next  = (state_reg == S_MEMWR) && !complete;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_FETCH;
      pc_reg     <= RESET_PC;
      oldpc_reg  <= RESET_PC;
      ir_reg     <= 32'd0;
      a_reg      <= 32'd0;
      b_reg      <= 32'd0;
      aluout_reg <= 32'd0;
      data_reg   <= 32'd0;
      req_reg    <= 1'b0;
      we_reg     <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= 32'd0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      oldpc_reg  <= oldpc_next;
      ir_reg     <= ir_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      aluout_reg <= aluout_next;
      data_reg   <= data_next;
      req_reg    <= req_next;
      we_reg     <= we_next;
      if (rf_we && rd != 5'd0) regs[rd[RIDX_W-1:0]] <= rf_wdata;
    end
  end

  logic [31:0] addr_full;
  assign addr_full = (state_reg == S_FETCH) ? pc_reg : aluout_reg;
  assign mem_addr  = addr_full[ADDR_W-1:0];
  assign mem_req   = req_reg;
  assign mem_we    = we_reg;
  assign mem_wdata = b_reg;
  assign pc_out    = pc_reg;
  assign trap      = (state_reg == S_TRAP);
  assign dbg_rdata = ({27'd0, dbg_raddr} < REG_LIMIT) ? regs[dbg_raddr[RIDX_W-1:0]] : 32'd0;

endmodule
